ped_signal: RTL and testbench

Pedestrian crossing signal stage that sits directly downstream of the traffic-light controller and consumes its `red`/`yellow`/`green` outputs. It latches pedestrian button requests and grants a WALK interval only at the start of a vehicle red phase. The WALK interval is followed by a flashing DON'T WALK countdown. Any loss of vehicle red, or an illegal light combination, forces solid DON'T WALK immediately.

---
 rtl/ped_signal.sv | 185 ++++++++++++++++++
 tb/tb_ped_signal.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ped_signal.sv
// Pedestrian crossing signal stage. It follows the vehicle light controller and
// grants WALK only at the start of a clean red phase. A flashing countdown follows WALK.
module ped_signal #(
   parameter int WALK_TIME  = 5,
   parameter int FLASH_TIME = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       red,
   input  logic       yellow,
   input  logic       green,
   input  logic       ped_btn,
   output logic       walk,
   output logic       dont_walk,
   output logic [3:0] countdown,
   output logic       req_pending,
   output logic       fault
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RED = 3'd1,
      ST_WALK     = 3'd2,
      ST_FLASH    = 3'd3,
      ST_HOLD     = 3'd4
   } state_t;

   localparam logic [7:0] WALK_LOAD  = 8'(WALK_TIME - 1);
   localparam logic [3:0] FLASH_LOAD = 4'(FLASH_TIME);

   // Exactly one vehicle lamp lit; anything else is treated as a light fault.
   function automatic logic one_hot3(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   state_t     state_r;
   state_t     state_nxt_s;
   logic       red_q_r;
   logic [7:0] walk_cnt_r;
   logic [7:0] walk_cnt_nxt_s;
   logic [3:0] flash_cnt_r;
   logic [3:0] flash_cnt_nxt_s;
   logic       lights_ok_s;
   logic       red_ok_s;
   logic       red_rise_s;
   logic       req_nxt_s;
   logic       walk_nxt_s;
   logic       dont_walk_nxt_s;
   logic [3:0] countdown_nxt_s;

   assign lights_ok_s = one_hot3({red, yellow, green});
   assign red_ok_s    = red & lights_ok_s;
   assign red_rise_s  = red_ok_s & ~red_q_r;

   // State, counters, red history and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         red_q_r     <= 1'b0;
         walk_cnt_r  <= 8'd0;
         flash_cnt_r <= 4'd0;
         walk        <= 1'b0;
         dont_walk   <= 1'b1;
         countdown   <= 4'd0;
         req_pending <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         red_q_r     <= red_ok_s;
         walk_cnt_r  <= walk_cnt_nxt_s;
         flash_cnt_r <= flash_cnt_nxt_s;
         walk        <= walk_nxt_s;
         dont_walk   <= dont_walk_nxt_s;
         countdown   <= countdown_nxt_s;
         req_pending <= req_nxt_s;
         fault       <= ~lights_ok_s;
      end
   end

   // Next-state selection, including the abort to HOLD whenever a clean red is lost.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_pending || ped_btn) begin
               state_nxt_s = ST_WAIT_RED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT_RED: begin
            if (red_rise_s) begin
               state_nxt_s = ST_WALK;
            end else begin
               state_nxt_s = ST_WAIT_RED;
            end
         end
         ST_WALK: begin
            if (!red_ok_s) begin
               state_nxt_s = ST_HOLD;
            end else if (walk_cnt_r == 8'd0) begin
               state_nxt_s = ST_FLASH;
            end else begin
               state_nxt_s = ST_WALK;
            end
         end
         ST_FLASH: begin
            if (!red_ok_s) begin
               state_nxt_s = ST_HOLD;
            end else if (flash_cnt_r <= 4'd1) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_FLASH;
            end
         end
         ST_HOLD: begin
            if (red_ok_s) begin
               state_nxt_s = ST_HOLD;
            end else if (req_pending) begin
               state_nxt_s = ST_WAIT_RED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Request latch: presses during WALK are ignored; elsewhere a press beats the grant clear.
   always_comb begin
      req_nxt_s = req_pending;
      if (state_r == ST_WALK) begin
         req_nxt_s = req_pending;
      end else if (ped_btn) begin
         req_nxt_s = 1'b1;
      end else if (state_nxt_s == ST_WALK) begin
         req_nxt_s = 1'b0;
      end else begin
         req_nxt_s = req_pending;
      end
   end

   // Output and counter values for the state being entered, registered on the next edge.
   always_comb begin
      walk_nxt_s      = 1'b0;
      dont_walk_nxt_s = 1'b1;
      countdown_nxt_s = 4'd0;
      walk_cnt_nxt_s  = walk_cnt_r;
      flash_cnt_nxt_s = flash_cnt_r;
      case (state_nxt_s)
         ST_WALK: begin
            walk_nxt_s      = 1'b1;
            dont_walk_nxt_s = 1'b0;
            if (state_r != ST_WALK) begin
               walk_cnt_nxt_s = WALK_LOAD;
            end else if (walk_cnt_r != 8'd0) begin
               walk_cnt_nxt_s = walk_cnt_r - 8'd1;
            end else begin
               walk_cnt_nxt_s = 8'd0;
            end
         end
         ST_FLASH: begin
            if (state_r != ST_FLASH) begin
               flash_cnt_nxt_s = FLASH_LOAD;
               dont_walk_nxt_s = 1'b1;
            end else if (flash_cnt_r != 4'd0) begin
               flash_cnt_nxt_s = flash_cnt_r - 4'd1;
               dont_walk_nxt_s = ~dont_walk;
            end else begin
               flash_cnt_nxt_s = 4'd0;
               dont_walk_nxt_s = ~dont_walk;
            end
            countdown_nxt_s = flash_cnt_nxt_s;
         end
         default: begin
            walk_nxt_s      = 1'b0;
            dont_walk_nxt_s = 1'b1;
            countdown_nxt_s = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_ped_signal.sv
// Directed bench for ped_signal: a cycle-by-cycle vector table followed by a
// measured WALK/FLASH sequence, with default parameters.
module tb_ped_signal;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       red = 1'b0;
   logic       yellow = 1'b0;
   logic       green = 1'b0;
   logic       ped_btn = 1'b0;
   logic       walk;
   logic       dont_walk;
   logic [3:0] countdown;
   logic       req_pending;
   logic       fault;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] R  = 3'b100;
   localparam logic [2:0] Y  = 3'b010;
   localparam logic [2:0] G  = 3'b001;
   localparam logic [2:0] RG = 3'b101;

   typedef struct {
      logic       rst;
      logic [2:0] rgb;
      logic       btn;
      logic       w;
      logic       dw;
      logic [3:0] cd;
      logic       req;
      logic       f;
   } vec_t;

   vec_t vecs[$];

   ped_signal #(.WALK_TIME(5), .FLASH_TIME(4)) dut (
      .clk(clk),
      .rst(rst),
      .red(red),
      .yellow(yellow),
      .green(green),
      .ped_btn(ped_btn),
      .walk(walk),
      .dont_walk(dont_walk),
      .countdown(countdown),
      .req_pending(req_pending),
      .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [2:0] rgb, input logic btn,
                      input logic w, input logic dw, input logic [3:0] cd,
                      input logic req, input logic f);
      vec_t v;
      v.rst = r; v.rgb = rgb; v.btn = btn;
      v.w = w; v.dw = dw; v.cd = cd; v.req = req; v.f = f;
      vecs.push_back(v);
   endtask

   task automatic cycle(input logic r, input logic [2:0] rgb, input logic btn);
      @(negedge clk);
      rst = r;
      {red, yellow, green} = rgb;
      ped_btn = btn;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int walk_cycles;
   int flash_cycles;
   int first_walk;
   logic [3:0] dw_seq;

   initial begin
      // reset with arbitrary (illegal) lights and a press
      add(1'b1, RG, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b1, RG, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // nominal grant
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // red phase without any request
      for (int i = 0; i < 3; i++) add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // press during a red already in progress, served at the next red start
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, Y, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      // abort: red drops on the third WALK cycle
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, Y, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // fault: red and green together during WALK
      add(1'b0, G, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, RG, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // reset in the middle of FLASH
      add(1'b0, G, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
      add(1'b1, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      // press ignored in WALK, press latched in HOLD and served next red
      add(1'b0, G, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      // press coinciding with red start in IDLE: no grant on that red
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      add(1'b0, R, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, R, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      add(1'b0, G, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].rgb, vecs[i].btn);
         checks++;
         if (walk !== vecs[i].w || dont_walk !== vecs[i].dw || countdown !== vecs[i].cd ||
             req_pending !== vecs[i].req || fault !== vecs[i].f) begin
            errors++;
            $display("FAIL vec%0d: got w=%b dw=%b cd=%0d req=%b f=%b expected w=%b dw=%b cd=%0d req=%b f=%b",
                     i, walk, dont_walk, countdown, req_pending, fault,
                     vecs[i].w, vecs[i].dw, vecs[i].cd, vecs[i].req, vecs[i].f);
         end
      end

      // Pending request from the table is waiting in WAIT_RED; measure a full grant over a bounded window.
      walk_cycles  = 0;
      flash_cycles = 0;
      first_walk   = -1;
      dw_seq       = 4'd0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, R, 1'b0);
         if (walk) begin
            walk_cycles++;
            if (first_walk < 0) first_walk = k;
         end
         if (countdown != 4'd0) begin
            flash_cycles++;
            dw_seq = {dw_seq[2:0], dont_walk};
         end
      end
      check("grant_latency", first_walk, 0);
      check("walk_cycles", walk_cycles, 5);
      check("flash_cycles", flash_cycles, 4);
      check("flash_pattern", int'(dw_seq), 10);
      cycle(1'b0, G, 1'b0);
      check("idle_after_green_dw", int'(dont_walk), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
